// File: rtl/rambus_playback_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : rambus_playback_sequencer
// Purpose  : Wishbone read master that streams 32-bit waveform words from a
//            RAM address window. Each word is split into four bytes, and the
//            bytes are driven to the DAC at a programmable sample period.
// Revision : 1.0 - initial release
// ============================================================================
module rambus_playback_sequencer #(
  parameter int ADDR_W = 8,
  parameter int DIV_W  = 16
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              cfg_enable,
  input  logic [ADDR_W-1:0] cfg_start_addr,
  input  logic [ADDR_W-1:0] cfg_end_addr,
  input  logic [DIV_W-1:0]  cfg_period,
  input  logic              cfg_oneshot,
  output logic              rambus_wb_cyc_o,
  output logic              rambus_wb_stb_o,
  output logic              rambus_wb_we_o,
  output logic [3:0]        rambus_wb_sel_o,
  output logic [ADDR_W-1:0] rambus_wb_adr_o,
  input  logic              rambus_wb_ack_i,
  input  logic [31:0]       rambus_wb_dat_i,
  output logic [7:0]        dac_o,
  output logic              sample_strobe_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              underrun_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [ADDR_W-1:0] r_start;
  logic [ADDR_W-1:0] r_end;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_adr;
  logic [DIV_W-1:0]  r_period;
  logic [DIV_W-1:0]  r_tick_cnt;
  logic              r_oneshot;
  logic              r_fetch_done;
  logic              r_cyc;
  logic              r_strobe;
  logic              r_underrun;
  logic [31:0]       r_fifo0;
  logic [31:0]       r_fifo1;
  logic [1:0]        r_count;
  logic [1:0]        r_lane;
  logic [7:0]        r_dac;

  logic              w_active;
  logic              w_tick;
  logic              w_has_data;
  logic              w_bus_ack;
  logic              w_push;
  logic              w_pop;
  logic              w_finish;
  logic              w_issue;

  // Playback only advances while a run is in progress and still requested.
  assign w_active   = ((r_state == S_FETCH) || (r_state == S_WAIT)) && cfg_enable;
  assign w_tick     = w_active && (r_tick_cnt == r_period);
  assign w_has_data = (r_count != 2'd0);
  assign w_bus_ack  = r_cyc && rambus_wb_ack_i;
  // Data acked during an abort is dropped, so only a live WAIT pushes.
  assign w_push     = (r_state == S_WAIT) && cfg_enable && rambus_wb_ack_i;
  assign w_pop      = w_tick && w_has_data && (r_lane == 2'd3);
  assign w_finish   = w_tick && !w_has_data && r_oneshot && r_fetch_done;
  assign w_issue    = (r_state == S_FETCH) && cfg_enable && (r_count != 2'd2) && !r_fetch_done;

  assign rambus_wb_cyc_o = r_cyc;
  assign rambus_wb_stb_o = r_cyc;
  assign rambus_wb_we_o  = 1'b0;
  assign rambus_wb_sel_o = r_cyc ? 4'hF : 4'h0;
  assign rambus_wb_adr_o = r_adr;
  assign dac_o           = r_dac;
  assign sample_strobe_o = r_strobe;
  assign underrun_o      = r_underrun;
  assign busy_o          = (r_state != S_IDLE);
  assign done_o          = (r_state == S_DONE);

  // State register.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: an enable drop wins, except that an open bus cycle must finish.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (cfg_enable) w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        if (!cfg_enable)   w_state_nxt = S_IDLE;
        else if (w_finish) w_state_nxt = S_DONE;
        else if (w_issue)  w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (!cfg_enable)          w_state_nxt = rambus_wb_ack_i ? S_IDLE : S_DRAIN;
        else if (rambus_wb_ack_i) w_state_nxt = S_FETCH;
      end
      S_DRAIN: begin
        if (rambus_wb_ack_i) w_state_nxt = S_IDLE;
      end
      S_DONE: begin
        if (!cfg_enable) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: config latch, bus request, address walk, word FIFO, and sample clocking.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_start      <= '0;
      r_end        <= '0;
      r_addr       <= '0;
      r_adr        <= '0;
      r_period     <= '0;
      r_tick_cnt   <= '0;
      r_oneshot    <= 1'b0;
      r_fetch_done <= 1'b0;
      r_cyc        <= 1'b0;
      r_strobe     <= 1'b0;
      r_underrun   <= 1'b0;
      r_fifo0      <= '0;
      r_fifo1      <= '0;
      r_count      <= '0;
      r_lane       <= '0;
      r_dac        <= '0;
    end else begin
      r_strobe <= 1'b0;

      // Idle keeps the FIFO flushed. A start snapshots the configuration.
      if (r_state == S_IDLE) begin
        r_count <= '0;
        r_lane  <= '0;
        if (cfg_enable) begin
          r_start      <= cfg_start_addr;
          r_end        <= cfg_end_addr;
          r_period     <= cfg_period;
          r_oneshot    <= cfg_oneshot;
          r_addr       <= cfg_start_addr;
          r_underrun   <= 1'b0;
          r_tick_cnt   <= '0;
          r_fetch_done <= 1'b0;
        end
      end

      if (w_issue) begin
        r_cyc <= 1'b1;
        r_adr <= r_addr;
      end else if (w_bus_ack) begin
        r_cyc <= 1'b0;
      end

      // A start address above the end address walks through the top of memory.
      if (w_push) begin
        if (r_addr == r_end) begin
          if (r_oneshot) r_fetch_done <= 1'b1;
          else           r_addr       <= r_start;
        end else begin
          r_addr <= r_addr + 1'b1;
        end
      end

      if (w_active) begin
        r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
      end

      if (w_tick) begin
        if (w_has_data) begin
          r_dac    <= r_fifo0[{r_lane, 3'b000} +: 8];
          r_strobe <= 1'b1;
          r_lane   <= r_lane + 2'd1;
        end else if (!(r_oneshot && r_fetch_done)) begin
          r_underrun <= 1'b1;
        end
      end

      case ({w_push, w_pop})
        2'b10: begin
          if (r_count == 2'd0) r_fifo0 <= rambus_wb_dat_i;
          else                 r_fifo1 <= rambus_wb_dat_i;
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_fifo0 <= r_fifo1;
          r_count <= r_count - 2'd1;
        end
        2'b11: begin
          if (r_count == 2'd1) begin
            r_fifo0 <= rambus_wb_dat_i;
          end else begin
            r_fifo0 <= r_fifo1;
            r_fifo1 <= rambus_wb_dat_i;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rambus_playback_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_rambus_playback_sequencer
// Purpose  : Scoreboard bench for the playback sequencer. A RAM slave model
//            answers bus reads. Expected samples and addresses come from the
//            window contents and are compared when the DUT presents them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rambus_playback_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_enable = 1'b0;
  logic [7:0]  cfg_start_addr = 8'h00;
  logic [7:0]  cfg_end_addr = 8'h00;
  logic [15:0] cfg_period = 16'h0000;
  logic        cfg_oneshot = 1'b0;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [7:0]  adr;
  logic        ack;
  logic [31:0] dat;
  logic [7:0]  dac;
  logic        strobe, busy, done, underrun;

  logic        slave_ack = 1'b0;
  logic        force_ack = 1'b0;
  logic        slave_en  = 1'b1;
  logic [31:0] slave_dat = 32'h0;
  int          slave_lat = 0;
  logic [31:0] ram [0:255];

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_samples [$];
  logic [7:0]  exp_addrs [$];
  int          run_id = 0;
  int          cur_period = 0;
  logic        stopped = 1'b1;
  int          tot_strobes = 0;
  int          tot_bus = 0;
  time         last_strobe_time = 0;

  assign ack = slave_ack | force_ack;
  assign dat = slave_dat;

  always #5 clk = ~clk;

  rambus_playback_sequencer #(.ADDR_W(8), .DIV_W(16)) dut (
    .wb_clk_i        (clk),
    .wb_rst_i        (rst),
    .cfg_enable      (cfg_enable),
    .cfg_start_addr  (cfg_start_addr),
    .cfg_end_addr    (cfg_end_addr),
    .cfg_period      (cfg_period),
    .cfg_oneshot     (cfg_oneshot),
    .rambus_wb_cyc_o (cyc),
    .rambus_wb_stb_o (stb),
    .rambus_wb_we_o  (we),
    .rambus_wb_sel_o (sel),
    .rambus_wb_adr_o (adr),
    .rambus_wb_ack_i (ack),
    .rambus_wb_dat_i (dat),
    .dac_o           (dac),
    .sample_strobe_o (strobe),
    .busy_o          (busy),
    .done_o          (done),
    .underrun_o      (underrun)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // RAM slave: acks after slave_lat cycles of strobe and returns that word.
  initial begin
    int lat_cnt;
    lat_cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (slave_ack) begin
        slave_ack = 1'b0;
      end else if (stb && slave_en) begin
        if (lat_cnt >= slave_lat) begin
          slave_ack = 1'b1;
          slave_dat = ram[adr];
          lat_cnt   = 0;
        end else begin
          lat_cnt++;
        end
      end else begin
        lat_cnt = 0;
      end
    end
  end

  // Monitor: pops the expected sample on each strobe and the expected address on each new bus cycle.
  initial begin
    logic       prev_stb, prev_ack, prev_rst;
    logic [7:0] prev_adr, exp_last, e;
    int         last_run, d;
    time        last_t;
    prev_stb = 1'b0; prev_ack = 1'b0; prev_rst = 1'b1; prev_adr = 8'h0;
    exp_last = 8'h0; last_run = -1; last_t = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_last = 8'h0;
      end else begin
        if (strobe) begin
          chk("strobe_while_stopped", {31'b0, stopped}, 32'd0);
          if (exp_samples.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL dac_sample: got 0x%0h with no sample expected at %0t", dac, $time);
          end else begin
            e = exp_samples.pop_front();
            chk("dac_sample", {24'b0, dac}, {24'b0, e});
            exp_last = e;
          end
          if (last_run == run_id) begin
            d = int'((($time - last_t) / 10));
            if (!underrun) chk("strobe_interval", d, cur_period + 1);
            else           chk("strobe_grid", d % (cur_period + 1), 0);
          end
          last_run = run_id;
          last_t = $time;
          last_strobe_time = $time;
          tot_strobes++;
        end else if (busy) begin
          chk("dac_hold", {24'b0, dac}, {24'b0, exp_last});
        end
        if (prev_stb && !prev_ack && !prev_rst) begin
          chk("stb_held", {31'b0, stb}, 32'd1);
          chk("adr_stable", {24'b0, adr}, {24'b0, prev_adr});
        end else if (stb) begin
          chk("sel_we", {27'b0, sel, we}, {27'b0, 4'hF, 1'b0});
          if (exp_addrs.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL adr_seq: got 0x%0h with no fetch expected at %0t", adr, $time);
          end else begin
            e = exp_addrs.pop_front();
            chk("adr_seq", {24'b0, adr}, {24'b0, e});
          end
          tot_bus++;
        end
      end
      prev_stb = stb; prev_ack = ack; prev_rst = rst; prev_adr = adr;
    end
  end

  // Reference model: window word k is ram[start + k mod len], and its bytes are played low byte first.
  task automatic start_run(input logic [7:0] s, input logic [7:0] e, input int p,
                           input logic os, input int lat);
    int         len, nwords;
    logic [7:0] a;
    logic [31:0] w;
    exp_samples.delete();
    exp_addrs.delete();
    len = int'(8'(e - s)) + 1;
    nwords = os ? len : 100;
    for (int k = 0; k < nwords; k++) begin
      a = 8'(int'(s) + (k % len));
      w = ram[a];
      exp_addrs.push_back(a);
      for (int b = 0; b < 4; b++) exp_samples.push_back(w[b*8 +: 8]);
    end
    slave_lat = lat;
    cur_period = p;
    run_id++;
    cfg_start_addr = s;
    cfg_end_addr = e;
    cfg_period = 16'(p);
    cfg_oneshot = os;
    stopped = 1'b0;
    cfg_enable = 1'b1;
  endtask

  task automatic wait_idle(input string name);
    for (int n = 0; n < 60 && busy; n++) tick();
    chk(name, {31'b0, busy}, 32'd0);
  endtask

  task automatic stop_run();
    cfg_enable = 1'b0;
    tick();
    stopped = 1'b1;
    wait_idle("stop_busy");
  endtask

  // Waits at the falling edge for a fresh strobe, so that ack is some cycles away.
  task automatic wait_fresh_stb();
    for (int n = 0; n < 200 && stb; n++) @(negedge clk);
    for (int n = 0; n < 200 && !stb; n++) @(negedge clk);
    chk("fresh_stb_seen", {31'b0, stb}, 32'd1);
  endtask

  task automatic wait_done();
    for (int n = 0; n < 2000 && !done; n++) @(negedge clk);
    chk("done_reached", {31'b0, done}, 32'd1);
  endtask

  initial begin
    int          b0, bus0, len, p, lat;
    logic [7:0]  s;
    logic        os;
    for (int i = 0; i < 256; i++) ram[i] = $urandom;
    ram[8'h10] = 32'h44332211;
    ram[8'h11] = 32'h88776655;

    rst = 1'b1;
    repeat (3) tick();
    chk("rst_cyc", {31'b0, cyc}, 32'd0);
    chk("rst_stb", {31'b0, stb}, 32'd0);
    chk("rst_sel", {28'b0, sel}, 32'd0);
    chk("rst_dac", {24'b0, dac}, 32'd0);
    chk("rst_strobe", {31'b0, strobe}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_underrun", {31'b0, underrun}, 32'd0);
    rst = 1'b0;
    tick();

    // Loop playback of a two-word window, with ack one cycle after strobe.
    b0 = tot_strobes;
    start_run(8'h10, 8'h11, 3, 1'b0, 1);
    repeat (40) tick();
    chk("loop_strobes", tot_strobes - b0, 9);
    chk("loop_underrun", {31'b0, underrun}, 32'd0);
    stop_run();

    // One-shot play of the same window.
    b0 = tot_strobes; bus0 = tot_bus;
    start_run(8'h10, 8'h11, 3, 1'b1, 1);
    wait_done();
    chk("oneshot_done_slot", 32'($time - last_strobe_time), 32'd40);
    chk("oneshot_strobes", tot_strobes - b0, 8);
    chk("oneshot_bus_cycles", tot_bus - bus0, 2);
    chk("oneshot_samples_left", exp_samples.size(), 0);
    stop_run();
    chk("oneshot_done_clear", {31'b0, done}, 32'd0);

    // Starvation: period 0 with slow RAM.
    b0 = tot_strobes;
    start_run(8'h10, 8'h11, 0, 1'b0, 20);
    repeat (300) tick();
    chk("starve_underrun", {31'b0, underrun}, 32'd1);
    chk("starve_resumes", {31'b0, (tot_strobes - b0) > 8}, 32'd1);
    stop_run();

    // Abort while a bus cycle is open: the cycle must complete before idle.
    start_run(8'h10, 8'h11, 2, 1'b0, 5);
    repeat (30) tick();
    wait_fresh_stb();
    cfg_enable = 1'b0;
    @(posedge clk);
    #1;
    stopped = 1'b1;
    chk("drain_cyc_held", {31'b0, cyc}, 32'd1);
    chk("drain_busy", {31'b0, busy}, 32'd1);
    wait_idle("drain_idle");
    repeat (4) tick();
    start_run(8'h20, 8'h23, 1, 1'b0, 0);
    repeat (40) tick();
    stop_run();

    // A window that wraps through the top of memory.
    bus0 = tot_bus;
    start_run(8'hFE, 8'h01, 1, 1'b0, 0);
    repeat (80) tick();
    chk("wrap_bus_cycles", {31'b0, (tot_bus - bus0) >= 5}, 32'd1);
    stop_run();

    // Reset during an open bus cycle; a later stray ack is ignored.
    start_run(8'h10, 8'h11, 1, 1'b0, 8);
    repeat (20) tick();
    wait_fresh_stb();
    rst = 1'b1;
    @(posedge clk);
    #1;
    stopped = 1'b1;
    cfg_enable = 1'b0;
    slave_en = 1'b0;
    chk("mid_rst_cyc", {31'b0, cyc}, 32'd0);
    chk("mid_rst_stb", {31'b0, stb}, 32'd0);
    chk("mid_rst_dac", {24'b0, dac}, 32'd0);
    chk("mid_rst_strobe", {31'b0, strobe}, 32'd0);
    chk("mid_rst_busy", {31'b0, busy}, 32'd0);
    chk("mid_rst_done", {31'b0, done}, 32'd0);
    chk("mid_rst_underrun", {31'b0, underrun}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    force_ack = 1'b1;
    slave_dat = $urandom;
    tick();
    force_ack = 1'b0;
    tick();
    chk("stray_ack_busy", {31'b0, busy}, 32'd0);
    chk("stray_ack_cyc", {31'b0, cyc}, 32'd0);
    chk("stray_ack_dac", {24'b0, dac}, 32'd0);
    exp_samples.delete();
    exp_addrs.delete();
    slave_en = 1'b1;

    // Randomized runs. Configuration inputs are scrambled after the start to show they are latched.
    for (int r = 0; r < 10; r++) begin
      s   = 8'($urandom);
      len = $urandom_range(1, 4);
      p   = $urandom_range(0, 4);
      lat = $urandom_range(0, 3);
      os  = 1'($urandom_range(0, 1));
      b0 = tot_strobes; bus0 = tot_bus;
      start_run(s, 8'(int'(s) + len - 1), p, os, lat);
      tick();
      cfg_start_addr = 8'($urandom);
      cfg_end_addr   = 8'($urandom);
      cfg_period     = 16'($urandom_range(0, 9));
      cfg_oneshot    = ~os;
      if (os) begin
        wait_done();
        chk("rnd_oneshot_strobes", tot_strobes - b0, 4 * len);
        chk("rnd_oneshot_bus", tot_bus - bus0, len);
        chk("rnd_oneshot_left", exp_samples.size(), 0);
      end else begin
        repeat ($urandom_range(50, 300)) tick();
      end
      stop_run();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/rambus_playback_sequencer.md
Name: rambus_playback_sequencer

Overview:
Wishbone master on the shared RAM bus. Fetches 32-bit waveform words from a configured address window in OpenRAM, unpacks each word into four 8-bit samples and drives them to the DAC pins at a programmable sample rate. It sits between the generator's register block, which supplies the configuration, and the rambus master port. It replaces free-running DAC updates with RAM-backed arbitrary-waveform playback.

Parameters:
ADDR_W, 8, rambus word-address width
DIV_W, 16, sample-period counter width

Ports:
wb_clk_i  in  1  system clock
wb_rst_i  in  1  synchronous reset, active-high
cfg_enable  in  1  run request; level-sensitive
cfg_start_addr  in  ADDR_W  first word address
cfg_end_addr  in  ADDR_W  last word address (inclusive)
cfg_period  in  DIV_W  sample period = cfg_period+1 clocks
cfg_oneshot  in  1  1: play window once; 0: loop
rambus_wb_cyc_o  out  1  bus cycle
rambus_wb_stb_o  out  1  strobe
rambus_wb_we_o  out  1  always 0
rambus_wb_sel_o  out  4  always 4'hF while cyc, else 0
rambus_wb_adr_o  out  ADDR_W  word address
rambus_wb_ack_i  in  1  ack
rambus_wb_dat_i  in  32  read data
dac_o  out  8  current sample
sample_strobe_o  out  1  1-cycle pulse when dac_o updates
busy_o  out  1  state != IDLE
done_o  out  1  oneshot finished (level, in DONE)
underrun_o  out  1  sticky: sample tick with no data

Behaviour:
- Reset (sync, highest priority, also mid-transaction): every output 0, FIFO empty, lane 0, tick counter 0, state IDLE; cyc/stb drop the next edge, no ack wait.
- FSM: IDLE, FETCH, WAIT, DONE, DRAIN.
- IDLE: when cfg_enable=1, latch all cfg_* (later changes are ignored until IDLE), set addr=start, clear underrun_o and the tick counter, then go to FETCH.
- FETCH: entered only when the word FIFO (2 entries) has a free slot. Assert cyc=stb=1 with adr=addr and go to WAIT. First stb appears 1 cycle after leaving IDLE.
- WAIT: hold cyc/stb/adr stable until ack. On ack: push dat_i and drop cyc/stb that same edge.
  - If addr==end: in oneshot, mark fetch_complete; in loop mode, addr=start.
  - Otherwise addr=addr+1 mod 2^ADDR_W, so end<start wraps through the top of memory.
  - Next state: FETCH if a slot is free and not fetch_complete; otherwise stay idle on the bus and re-enter FETCH when a slot frees.
- Only one outstanding transaction. The FIFO never overflows because a fetch is issued only when count<2.
- Tick: the counter runs 0..cfg_period and ticks when it equals cfg_period. First tick comes cfg_period+1 cycles after leaving IDLE. Period 0 gives a tick every cycle.
- On tick with FIFO non-empty:
  - dac_o = head byte[lane*8+:8], with byte 0 (bits 7:0) first; sample_strobe_o=1.
  - lane++; when lane 3 is consumed, pop the head and set lane=0.
- On tick with FIFO empty:
  - Loop mode, or oneshot before fetch_complete: underrun_o=1 (sticky), dac_o holds, no strobe.
  - Oneshot after fetch_complete: go to DONE.
- Simultaneous pop and ack: both take effect the same edge; count is unchanged and the pushed word lands behind the remaining entry. When the FIFO is empty, the ack'd word is usable at the next tick, not the same edge.
- DONE: done_o=1, bus idle, dac_o holds. Return to IDLE when cfg_enable=0.
- cfg_enable=0 in FETCH/IDLE-bus: go to IDLE next edge.
- cfg_enable=0 in WAIT: go to DRAIN, keep cyc/stb until ack and discard the data, then go to IDLE.
- Entering IDLE flushes the FIFO and sets lane=0. dac_o holds its last value; underrun_o holds until the next start.

Test Plan:
- RAM[0x10]=0x44332211, RAM[0x11]=0x88776655, start=0x10, end=0x11, period=3, loop, ack 1 cycle after stb -> dac_o 11,22,33,44,55,66,77,88,11 with a strobe every 4 cycles; adr sequence 10,11,10; underrun_o=0.
- Same setup with oneshot=1 -> exactly 8 strobes, only 2 bus cycles, done_o=1 on the 9th tick slot; cfg_enable=0 -> busy_o=0.
- period=0, ack latency 20 cycles -> underrun_o=1 after 4 strobes, dac_o holds 0x44 (or the last byte) with no strobes while starved, playback resumes after ack.
- Drop cfg_enable while stb is high, ack 5 cycles later -> cyc/stb held 5 cycles, then busy_o=0, no further strobes, FIFO empty on restart (first sample = byte 0 of start word).
- start=0xFE, end=0x01, loop -> adr sequence FE,FF,00,01,FE.
- Assert wb_rst_i mid-WAIT -> next edge: cyc/stb/dac_o/strobe/busy/done/underrun all 0; a later ack is ignored.
